// File: rtl/stage_tag_pipe_if.sv
// Hazard-tag bundle between decode and the E/M/W tag pipeline.
// Master drives the D-stage tag and stall; slave returns per-stage tags.
interface stage_tag_pipe_if;
   logic        stall;
   logic [4:0]  D_rs_base, D_rt, D_REG_write_number;
   logic        D_REG_write_enable;
   logic [1:0]  D_T_new, D_T_use_rs_base, D_T_use_rt;
   logic        D_valid;

   logic [4:0]  E_rs_base, E_rt, E_REG_write_number;
   logic        E_REG_write_enable;
   logic [1:0]  E_T_new, E_T_use_rs_base, E_T_use_rt;
   logic        E_valid;

   logic [4:0]  M_rs_base, M_rt, M_REG_write_number;
   logic        M_REG_write_enable;
   logic [1:0]  M_T_new, M_T_use_rs_base, M_T_use_rt;
   logic        M_valid;

   logic [4:0]  W_rs_base, W_rt, W_REG_write_number;
   logic        W_REG_write_enable;
   logic [1:0]  W_T_new, W_T_use_rs_base, W_T_use_rt;
   logic        W_valid;

   logic [15:0] stall_count;

   modport master (
      output stall, D_rs_base, D_rt, D_REG_write_number, D_REG_write_enable,
             D_T_new, D_T_use_rs_base, D_T_use_rt, D_valid,
      input  E_rs_base, E_rt, E_REG_write_number, E_REG_write_enable,
             E_T_new, E_T_use_rs_base, E_T_use_rt, E_valid,
             M_rs_base, M_rt, M_REG_write_number, M_REG_write_enable,
             M_T_new, M_T_use_rs_base, M_T_use_rt, M_valid,
             W_rs_base, W_rt, W_REG_write_number, W_REG_write_enable,
             W_T_new, W_T_use_rs_base, W_T_use_rt, W_valid,
             stall_count
   );

   modport slave (
      input  stall, D_rs_base, D_rt, D_REG_write_number, D_REG_write_enable,
             D_T_new, D_T_use_rs_base, D_T_use_rt, D_valid,
      output E_rs_base, E_rt, E_REG_write_number, E_REG_write_enable,
             E_T_new, E_T_use_rs_base, E_T_use_rt, E_valid,
             M_rs_base, M_rt, M_REG_write_number, M_REG_write_enable,
             M_T_new, M_T_use_rs_base, M_T_use_rt, M_valid,
             W_rs_base, W_rt, W_REG_write_number, W_REG_write_enable,
             W_T_new, W_T_use_rs_base, W_T_use_rt, W_valid,
             stall_count
   );
endinterface

// File: rtl/stage_tag_pipe.sv
// E/M/W hazard-tag pipeline: carries register numbers and T_new/T_use timing
// tags behind the instruction, ageing timing tags by one per stage.
module stage_tag_pipe (
   input  logic            clk,
   input  logic            reset,
   stage_tag_pipe_if.slave p
);
   typedef struct packed {
      logic [4:0] rs_base;
      logic [4:0] rt;
      logic [4:0] wr_num;
      logic       wr_en;
      logic [1:0] t_new;
      logic [1:0] t_use_rs;
      logic [1:0] t_use_rt;
      logic       valid;
   } tag_t;

   function automatic logic [1:0] sat_dec(input logic [1:0] v);
      return (v == 2'd0) ? 2'd0 : v - 2'd1;
   endfunction

   function automatic tag_t age(input tag_t t);
      tag_t a;
      a          = t;
      a.t_new    = sat_dec(t.t_new);
      a.t_use_rs = sat_dec(t.t_use_rs);
      a.t_use_rt = sat_dec(t.t_use_rt);
      return a;
   endfunction

   tag_t        d_tag, e_q, m_q, w_q;
   logic [15:0] stall_cnt_q;

   // T_new is not aged on entry to E (it counts from E); T_use counts from D.
   always_comb begin
      d_tag          = '0;
      d_tag.rs_base  = p.D_rs_base;
      d_tag.rt       = p.D_rt;
      d_tag.wr_num   = p.D_REG_write_number;
      d_tag.wr_en    = p.D_REG_write_enable && p.D_valid && (p.D_REG_write_number != 5'd0);
      d_tag.t_new    = p.D_T_new;
      d_tag.t_use_rs = sat_dec(p.D_T_use_rs_base);
      d_tag.t_use_rt = sat_dec(p.D_T_use_rt);
      d_tag.valid    = p.D_valid;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_q         <= '0;
         m_q         <= '0;
         w_q         <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (p.stall) e_q <= '0;
         else         e_q <= d_tag;
         m_q <= age(e_q);
         w_q <= age(m_q);
         if (p.stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign p.E_rs_base          = e_q.rs_base;
   assign p.E_rt               = e_q.rt;
   assign p.E_REG_write_number = e_q.wr_num;
   assign p.E_REG_write_enable = e_q.wr_en;
   assign p.E_T_new            = e_q.t_new;
   assign p.E_T_use_rs_base    = e_q.t_use_rs;
   assign p.E_T_use_rt         = e_q.t_use_rt;
   assign p.E_valid            = e_q.valid;

   assign p.M_rs_base          = m_q.rs_base;
   assign p.M_rt               = m_q.rt;
   assign p.M_REG_write_number = m_q.wr_num;
   assign p.M_REG_write_enable = m_q.wr_en;
   assign p.M_T_new            = m_q.t_new;
   assign p.M_T_use_rs_base    = m_q.t_use_rs;
   assign p.M_T_use_rt         = m_q.t_use_rt;
   assign p.M_valid            = m_q.valid;

   assign p.W_rs_base          = w_q.rs_base;
   assign p.W_rt               = w_q.rt;
   assign p.W_REG_write_number = w_q.wr_num;
   assign p.W_REG_write_enable = w_q.wr_en;
   assign p.W_T_new            = w_q.t_new;
   assign p.W_T_use_rs_base    = w_q.t_use_rs;
   assign p.W_T_use_rt         = w_q.t_use_rt;
   assign p.W_valid            = w_q.valid;

   assign p.stall_count        = stall_cnt_q;
endmodule

// File: tb/tb_stage_tag_pipe.sv
// Directed bench for stage_tag_pipe: hand-computed tag values per stage,
// stall bubbles, counter saturation and asynchronous reset.
module tb_stage_tag_pipe;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   stage_tag_pipe_if bus ();

   stage_tag_pipe dut (
      .clk   (clk),
      .reset (reset),
      .p     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_d(input logic vld, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] wn, input logic we, input logic [1:0] tn,
                          input logic [1:0] urs, input logic [1:0] urt);
      bus.D_valid            = vld;
      bus.D_rs_base          = rs;
      bus.D_rt               = rt;
      bus.D_REG_write_number = wn;
      bus.D_REG_write_enable = we;
      bus.D_T_new            = tn;
      bus.D_T_use_rs_base    = urs;
      bus.D_T_use_rt         = urt;
   endtask

   task automatic chk_all_zero(input string tag);
      logic [31:0] e_cat, m_cat, w_cat;
      e_cat = {bus.E_rs_base, bus.E_rt, bus.E_REG_write_number, bus.E_REG_write_enable,
               bus.E_T_new, bus.E_T_use_rs_base, bus.E_T_use_rt, bus.E_valid};
      m_cat = {bus.M_rs_base, bus.M_rt, bus.M_REG_write_number, bus.M_REG_write_enable,
               bus.M_T_new, bus.M_T_use_rs_base, bus.M_T_use_rt, bus.M_valid};
      w_cat = {bus.W_rs_base, bus.W_rt, bus.W_REG_write_number, bus.W_REG_write_enable,
               bus.W_T_new, bus.W_T_use_rs_base, bus.W_T_use_rt, bus.W_valid};
      chk({tag, "_E"}, e_cat, 32'd0);
      chk({tag, "_M"}, m_cat, 32'd0);
      chk({tag, "_W"}, w_cat, 32'd0);
      chk({tag, "_cnt"}, 32'(bus.stall_count), 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      bus.stall = 1'b0;
      drive_d(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 2'd1, 2'd1, 2'd1);
      #1;
      chk_all_zero("rst_async");
      step();
      chk_all_zero("rst_hold_edge");
      reset = 1'b0;

      // write-back tag ages through the pipe
      drive_d(1'b1, 5'd3, 5'd4, 5'd8, 1'b1, 2'd2, 2'd3, 2'd1);
      step();
      drive_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 2'd0, 2'd0);
      chk("e_tnew",   32'(bus.E_T_new), 32'd2);
      chk("e_urt",    32'(bus.E_T_use_rt), 32'd0);
      chk("e_urs",    32'(bus.E_T_use_rs_base), 32'd2);
      chk("e_we",     32'(bus.E_REG_write_enable), 32'd1);
      chk("e_rs_rt",  32'({bus.E_rs_base, bus.E_rt}), 32'({5'd3, 5'd4}));
      chk("e_valid",  32'(bus.E_valid), 32'd1);
      step();
      chk("m_tnew",   32'(bus.M_T_new), 32'd1);
      chk("m_urs",    32'(bus.M_T_use_rs_base), 32'd1);
      chk("m_urt",    32'(bus.M_T_use_rt), 32'd0);
      chk("m_wn",     32'(bus.M_REG_write_number), 32'd8);
      chk("e_empty",  32'(bus.E_valid), 32'd0);
      step();
      chk("w_tnew",   32'(bus.W_T_new), 32'd0);
      chk("w_wn",     32'(bus.W_REG_write_number), 32'd8);
      chk("w_urs",    32'(bus.W_T_use_rs_base), 32'd0);
      chk("w_we",     32'(bus.W_REG_write_enable), 32'd1);
      chk("w_valid",  32'(bus.W_valid), 32'd1);

      // write to $0 and invalid instruction never enable
      drive_d(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 2'd0, 2'd0, 2'd0);
      step();
      chk("r0_we",    32'(bus.E_REG_write_enable), 32'd0);
      chk("r0_wn",    32'(bus.E_REG_write_number), 32'd0);
      chk("r0_valid", 32'(bus.E_valid), 32'd1);
      drive_d(1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 2'd0, 2'd0, 2'd0);
      step();
      chk("inv_we",   32'(bus.E_REG_write_enable), 32'd0);
      chk("inv_wn",   32'(bus.E_REG_write_number), 32'd5);

      // zero tags stay zero
      drive_d(1'b1, 5'd6, 5'd7, 5'd3, 1'b1, 2'd0, 2'd0, 2'd0);
      step();
      drive_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 2'd0, 2'd0);
      chk("z_e", 32'({bus.E_T_new, bus.E_T_use_rs_base, bus.E_T_use_rt}), 32'd0);
      step();
      chk("z_m", 32'({bus.M_T_new, bus.M_T_use_rs_base, bus.M_T_use_rt}), 32'd0);
      step();
      chk("z_w", 32'({bus.W_T_new, bus.W_T_use_rs_base, bus.W_T_use_rt}), 32'd0);
      chk("z_w_rs", 32'(bus.W_rs_base), 32'd6);

      // two stall edges insert bubbles; D enters once stall drops
      drive_d(1'b1, 5'd5, 5'd9, 5'd10, 1'b1, 2'd1, 2'd2, 2'd2);
      bus.stall = 1'b1;
      step();
      chk("st1_ev",  32'(bus.E_valid), 32'd0);
      chk("st1_ers", 32'(bus.E_rs_base), 32'd0);
      chk("st1_ewe", 32'(bus.E_REG_write_enable), 32'd0);
      chk("st1_cnt", 32'(bus.stall_count), 32'd1);
      step();
      chk("st2_ev",  32'(bus.E_valid), 32'd0);
      chk("st2_mv",  32'(bus.M_valid), 32'd0);
      chk("st2_cnt", 32'(bus.stall_count), 32'd2);
      bus.stall = 1'b0;
      step();
      chk("st3_ers", 32'(bus.E_rs_base), 32'd5);
      chk("st3_ev",  32'(bus.E_valid), 32'd1);
      chk("st3_mv",  32'(bus.M_valid), 32'd0);
      chk("st3_wv",  32'(bus.W_valid), 32'd0);
      chk("st3_cnt", 32'(bus.stall_count), 32'd2);

      // fill pipe, then reset between edges
      drive_d(1'b1, 5'd7, 5'd7, 5'd7, 1'b1, 2'd3, 2'd3, 2'd3);
      step();
      step();
      step();
      chk("full_wv", 32'(bus.W_valid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk_all_zero("rst_mid");
      #2;
      reset = 1'b0;
      drive_d(1'b1, 5'd9, 5'd1, 5'd2, 1'b1, 2'd1, 2'd1, 2'd1);
      step();
      chk("rl_ers", 32'(bus.E_rs_base), 32'd9);
      chk("rl_ev",  32'(bus.E_valid), 32'd1);
      chk("rl_mv",  32'(bus.M_valid), 32'd0);
      chk("rl_wv",  32'(bus.W_valid), 32'd0);
      chk("rl_mrs", 32'(bus.M_rs_base), 32'd0);

      // counter saturation
      bus.stall = 1'b1;
      for (int i = 0; i < 65534; i++) @(posedge clk);
      #1;
      chk("cnt_fffe", 32'(bus.stall_count), 32'hFFFE);
      step();
      chk("cnt_ffff", 32'(bus.stall_count), 32'hFFFF);
      step();
      chk("cnt_sat",  32'(bus.stall_count), 32'hFFFF);
      bus.stall = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
